// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - scan/test controller for a scannable datapath stage (optional SCAN_CTRL_PAUSE_EN adds scan_pause)
module scan_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic                 cmd_sel,
    input  logic [CHAIN_LEN-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_rdata,
    output logic                 scan_sen,
    output logic                 scan_ce,
    output logic                 scan_sin,
    input  logic                 scan_sout,
`ifdef SCAN_CTRL_PAUSE_EN
    input  logic                 scan_pause,
`endif
    output logic                 func_en,
    output logic                 func_sel
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FUNC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_FUNC = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CHAIN = CNT_W'(CHAIN_LEN);

    // Pause request; tied off when the feature is not built in.
    logic pause;
`ifdef SCAN_CTRL_PAUSE_EN
    assign pause = scan_pause;
`else
    assign pause = 1'b0;
`endif

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    // shreg[MSB] is always the bit due on scan_sin in the next shift cycle
    logic [CHAIN_LEN-1:0]   shreg, shreg_n;
    logic [CHAIN_LEN-1:0]   cap, cap_n;
    logic                   load_q, load_n;
    logic                   sel_q, sel_n;

    logic                   cmd_ready_n;
    logic                   rsp_valid_n;
    logic [CHAIN_LEN-1:0]   rsp_rdata_n;
    logic                   sen_n;
    logic                   ce_n;
    logic                   sin_n;
    logic                   fen_n;
    logic                   fsel_n;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        cap_n       = cap;
        load_n      = load_q;
        sel_n       = sel_q;
        cmd_ready_n = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        sen_n       = 1'b0;
        ce_n        = 1'b0;
        sin_n       = 1'b0;
        fen_n       = 1'b0;
        fsel_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load_n = (cmd_op == OP_LOAD);
                    sel_n  = cmd_sel;
                    if (cmd_op == OP_FUNC) begin
                        if (cmd_wdata[15:0] != 16'd0) begin
                            state_n = ST_FUNC;
                            cnt_n   = CNT_W'(cmd_wdata[15:0]);
                            fen_n   = 1'b1;
                            fsel_n  = cmd_sel;
                        end else begin
                            // Zero-length run answers immediately
                            state_n     = ST_RESP;
                            cnt_n       = '0;
                            rsp_valid_n = 1'b1;
                            rsp_rdata_n = '0;
                        end
                    end else begin
                        // DUMP shifts zeros in, so it simply loads an all-zero word
                        state_n = ST_SHIFT;
                        cnt_n   = CNT_CHAIN;
                        shreg_n = (cmd_op == OP_DUMP) ? '0 : cmd_wdata;
                        cap_n   = '0;
                        sen_n   = 1'b1;
                        ce_n    = 1'b1;
                        sin_n   = (cmd_op == OP_DUMP) ? 1'b0 : cmd_wdata[CHAIN_LEN-1];
                    end
                end else begin
                    cmd_ready_n = 1'b1;
                end
            end

            ST_SHIFT: begin
                // Default for the next cycle: keep scanning, hold sin if paused
                sen_n = 1'b1;
                ce_n  = !pause;
                sin_n = scan_sin;
                // A shift happens only in cycles where scan_ce was actually high
                if (scan_ce) begin
                    cap_n   = {cap[CHAIN_LEN-2:0], scan_sout};
                    cnt_n   = cnt - CNT_ONE;
                    shreg_n = shreg << 1;
                    if (cnt == CNT_ONE) begin
                        state_n     = ST_RESP;
                        sen_n       = 1'b0;
                        ce_n        = 1'b0;
                        sin_n       = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = load_q ? '0 : {cap[CHAIN_LEN-2:0], scan_sout};
                    end else if (!pause) begin
                        sin_n = shreg[CHAIN_LEN-2];
                    end
                end else if (!pause) begin
                    sin_n = shreg[CHAIN_LEN-1];
                end
            end

            ST_FUNC: begin
                fen_n  = !pause;
                fsel_n = sel_q;
                // Only cycles with func_en high count toward N
                if (func_en) begin
                    cnt_n = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_n     = ST_RESP;
                        fen_n       = 1'b0;
                        fsel_n      = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = '0;
                    end
                end
            end

            ST_RESP: begin
                rsp_valid_n = 1'b1;
                if (rsp_valid && rsp_ready) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            cap       <= '0;
            load_q    <= 1'b0;
            sel_q     <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            scan_sen  <= 1'b0;
            scan_ce   <= 1'b0;
            scan_sin  <= 1'b0;
            func_en   <= 1'b0;
            func_sel  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            cap       <= cap_n;
            load_q    <= load_n;
            sel_q     <= sel_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            scan_sen  <= sen_n;
            scan_ce   <= ce_n;
            scan_sin  <= sin_n;
            func_en   <= fen_n;
            func_sel  <= fsel_n;
        end
    end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
Scan/test controller that sits directly upstream of the 32-bit scannable datapath stage. It drives that stage's scan enable, scan clock-enable, scan input, register enable and register select, and samples its scan output. A host issues commands over a valid/ready interface: load a word into the chain, dump the chain, swap (load while dumping), or run N functional cycles. Each command returns exactly one response word.

Parameters:
CHAIN_LEN, 32, number of flops in the scan chain and width of command/response data words; must be >=16.
CNT_W, 16, width of the shift/functional cycle counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command (high only in IDLE)
cmd_op  input  2  00 FUNC, 01 LOAD, 10 DUMP, 11 SWAP
cmd_sel  input  1  value for func_sel during FUNC
cmd_wdata  input  CHAIN_LEN  LOAD/SWAP: word to shift in; FUNC: bits [15:0] = cycle count N
rsp_valid  output  1  response present
rsp_ready  input  1  host accepts response
rsp_rdata  output  CHAIN_LEN  DUMP/SWAP: captured chain contents; LOAD/FUNC: all zeros
scan_sen  output  1  to datapath sen
scan_ce  output  1  to datapath scan_ce
scan_sin  output  1  to datapath sin
scan_sout  input  1  from datapath sout
func_en  output  1  to datapath reg_en
func_sel  output  1  to datapath reg_sel

Behaviour:
- All outputs registered. Reset values: cmd_ready=0 during reset cycle, then 1; rsp_valid=0; rsp_rdata=0; scan_sen=0; scan_ce=0; scan_sin=0; func_en=0; func_sel=0; state=IDLE; counter=0.
- States: IDLE, SHIFT, FUNC, RESP.
- IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready. LOAD/DUMP/SWAP -> SHIFT; FUNC with N>0 -> FUNC; FUNC with N=0 -> RESP directly. cmd_wdata, cmd_op and cmd_sel latched at accept.
- SHIFT: exactly CHAIN_LEN cycles with scan_sen=1 and scan_ce=1. Bit order MSB first: in shift cycle k (k=0..CHAIN_LEN-1), scan_sin = wdata[CHAIN_LEN-1-k]. DUMP drives scan_sin=0. On each edge that ends a shift cycle, scan_sout is shifted into the capture register LSB. After CHAIN_LEN cycles, the first sampled bit is in rsp_rdata[CHAIN_LEN-1]. scan_sen and scan_ce drop to 0 in the cycle after the last shift; the state goes to RESP.
- FUNC: func_en=1 for exactly N consecutive cycles; func_sel=latched cmd_sel; scan_sen=0 and scan_ce=0 throughout. Then func_en=0 and the state goes to RESP. func_sel returns to 0 when the state leaves FUNC.
- RESP: rsp_valid=1, rsp_rdata stable until rsp_valid&&rsp_ready. Then the state goes to IDLE with cmd_ready=1 on the next cycle. There is no command/response overlap.
- Latency: command accepted at edge 0 gives SHIFT cycles 1..CHAIN_LEN and rsp_valid at cycle CHAIN_LEN+1. FUNC gives rsp_valid at cycle N+1. FUNC N=0 gives rsp_valid at cycle 1.
- cmd_valid outside IDLE is ignored; the command is not lost because cmd_ready=0.
- Counter: counts down from CHAIN_LEN or N; there is no wrap. N up to 2^16-1 is supported, so CNT_W must be >=16.
- Reset mid-SHIFT, mid-FUNC or in RESP: next cycle is IDLE with all outputs at reset values. The partially shifted chain content is undefined; the datapath stage is cleared by the same reset.
- scan_sen and func_en are never high in the same cycle.

Optional Feature:
SCAN_CTRL_PAUSE_EN
- Defined: adds input port scan_pause (1 bit). While scan_pause=1 in SHIFT: scan_ce=0, scan_sen stays 1, scan_sin holds its value, the counter and capture register freeze, and scan_sout is not sampled. Shifting resumes on the cycle after scan_pause falls. Pause in FUNC likewise holds func_en=0 and freezes the counter. Pause has no effect in IDLE or RESP.
- Undefined: no scan_pause port; shifting and functional runs are uninterrupted and latency is fixed as above.

Test Plan:
Bench attaches the 32-bit increment-feedback datapath stage downstream.
1. LOAD 0xA5A50F0F, then DUMP -> DUMP rsp_rdata=0xA5A50F0F; LOAD rsp_rdata=0; rsp_valid exactly at cycle 33 after each accept.
2. LOAD 0x00000010, FUNC N=3 sel=0, DUMP -> 0x00000013; func_en high exactly 3 cycles; scan_sen=0 throughout FUNC.
3. LOAD 0x12345678, SWAP 0xDEADBEEF, DUMP -> SWAP returns 0x12345678; DUMP returns 0xDEADBEEF.
4. FUNC N=0 -> rsp_valid at cycle 1; func_en never asserted. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable and cmd_ready=0 until handshake.
5. Assert reset at shift cycle 10 of a LOAD -> next cycle IDLE, scan_sen=scan_ce=0, rsp_valid=0. A following DUMP returns 0x00000000.
6. (SCAN_CTRL_PAUSE_EN) LOAD 0xF0F0F0F0 with scan_pause high for 4 cycles mid-shift -> rsp_valid at cycle 37. A following DUMP returns 0xF0F0F0F0.
